mat_mul_acc: RTL
================

MAT_MUL_ACC -- requirements
Module: mat_mul_acc

Interface
REQ-001 SHALL have parameter W_IN, default 8, signed/unsigned element width of input matrices.
REQ-002 SHALL have parameter W_OUT, default 32, width of each result element and accumulator.
REQ-003 SHALL have parameter N, default 8, matrix tile dimension (N x N).
REQ-004 SHALL have parameter TILES, default 4, maximum K-tiles accumulated per job.
REQ-005 SHALL have ports, in order:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  input beat valid.
- ready_in  out  1  block accepts beat.
- last_in  in  1  beat is final K-tile of job.
- signed_mode  in  1  1 = signed operands, 0 = unsigned; sampled with each accepted beat.
- matrix_1  in  N*N*W_IN  A tile, row-major [i][k].
- matrix_2  in  N*N*W_IN  B tile, row-major [k][j].
- valid_out  out  1  result valid.
- ready_out  in  1  consumer accepts result.
- result  out  N*N*W_OUT  accumulated C = sum of A*B over job.
- tile_ovf  out  1  job terminated by tile limit rather than last_in; valid with valid_out.
REQ-006 SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-007 Beat accepted when valid_in && ready_in at rising clk edge.
REQ-008 Pipeline: one product register stage, clog2(N) adder-tree stages, one accumulate stage; accepted beats SHALL stream back-to-back.
REQ-009 Latency: last beat accepted at edge t -> valid_out high after edge t+clog2(N)+2.
REQ-010 Products SHALL be formed at 2*W_IN+1 bits, sign- or zero-extended per beat's signed_mode, then extended to W_OUT.
REQ-011 Accumulation SHALL wrap modulo 2^W_OUT unless MAT_MUL_SAT_EN is defined.
REQ-012 FSM states: IDLE, ACCUM, DRAIN, HOLD.
REQ-013 IDLE/ACCUM: ready_in=1; accept without last -> ACCUM; accept with last_in, or the TILES-th beat of job -> DRAIN.
REQ-014 DRAIN: ready_in=0; -> HOLD when final beat leaves accumulate stage.
REQ-015 HOLD: valid_out=1, result and tile_ovf stable while ready_out=0; on ready_out -> IDLE, accumulator cleared, ready_in=1 next cycle.
REQ-016 tile_ovf=1 only if TILES-th beat accepted with last_in=0; TILES-th beat with last_in=1 gives tile_ovf=0.
REQ-017 valid_in low in ACCUM SHALL insert bubbles without affecting the sum.
REQ-018 ready_out while valid_out=0 SHALL have no effect.

Reset
REQ-019 reset SHALL immediately force IDLE, ready_in=1 (after release), valid_out=0, tile_ovf=0, result=0, accumulator=0, all pipeline valids=0.
REQ-020 Reset mid-ACCUM or mid-DRAIN SHALL discard the job; no valid_out SHALL follow.

Configuration
REQ-021 MAT_MUL_SAT_EN defined: accumulate SHALL saturate to signed W_OUT bounds (signed_mode=1) or to 2^W_OUT-1 (signed_mode=0).
REQ-022 MAT_MUL_SAT_EN undefined: no saturation logic; wrap per REQ-011.

Structure
REQ-023 Package mat_mul_pkg SHALL hold the state enum type, pipeline depth constant function (clog2(N)+2) and element/tile typedef helpers.
REQ-024 Sub-module mat_mul_dot SHALL compute one N-length dot product with registered adder tree; mat_mul_acc SHALL instantiate N*N copies.

Verification (N=4, W_IN=8, W_OUT=32, TILES=4 unless stated)
REQ-025 A=identity, B[k][j]=k*4+j, signed, last_in=1 single beat -> result=B, valid_out exactly 4 cycles after accept, tile_ovf=0.
REQ-026 4 back-to-back beats, all elements -128, signed, last on 4th -> every element 262144.
REQ-027 1 beat all 255, signed_mode=0 -> every element 260100; same with signed_mode=1 -> every element 4.
REQ-028 ready_out held low 5 cycles in HOLD -> result stable, ready_in=0; ready_out high -> valid_out low and ready_in high next cycle.
REQ-029 5 beats with last_in=0 -> first 4 form job, tile_ovf=1; 5th accepted only after result handshake.
REQ-030 reset asserted 2 cycles after last beat -> no valid_out; with MAT_MUL_SAT_EN, W_OUT=18, REQ-026 stimulus -> every element 131071.

Source files
------------

// File: rtl/mat_mul_pkg.sv
// Shared types and sizing helpers for the mat_mul_acc tile multiplier-accumulator.
package mat_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Beat-to-accumulator depth: product register + adder tree + accumulate register.
    function automatic int pipe_depth(input int n);
        return $clog2(n) + 2;
    endfunction

    function automatic int prod_width(input int w_in);
        return 2 * w_in + 1;
    endfunction

    function automatic int sum_width(input int w_in, input int n);
        return prod_width(w_in) + $clog2(n);
    endfunction

    // LSB of element [row][col] in a row-major flattened n x n tile.
    function automatic int elem_lsb(input int row, input int col, input int n, input int w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/mat_mul_dot.sv
// One N-length dot product: registered products feeding a registered binary adder tree.
module mat_mul_dot
    import mat_mul_pkg::*;
#(
    parameter int W_IN = 8,
    parameter int N    = 8
) (
    input  logic                                    clk,
    input  logic                                    signed_mode,
    input  logic [N*W_IN-1:0]                       a_row,
    input  logic [N*W_IN-1:0]                       b_col,
    output logic signed [sum_width(W_IN, N)-1:0]    dot_sum
);
    localparam int PROD_W = prod_width(W_IN);
    localparam int SUM_W  = sum_width(W_IN, N);
    localparam int LVLS   = $clog2(N);
    localparam int NP2    = 1 << LVLS;

    // One extra operand bit lets a single signed multiplier serve both modes.
    function automatic logic signed [PROD_W-1:0] mul_ext(input logic [W_IN-1:0] a,
                                                         input logic [W_IN-1:0] b,
                                                         input logic sgn);
        logic signed [W_IN:0] ax;
        logic signed [W_IN:0] bx;
        ax = {sgn & a[W_IN-1], a};
        bx = {sgn & b[W_IN-1], b};
        return PROD_W'(ax) * PROD_W'(bx);
    endfunction

    logic signed [PROD_W-1:0] prod_p0 [N];
    logic signed [SUM_W-1:0]  leaf    [NP2];

    // product stage
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            prod_p0[k] <= mul_ext(a_row[k*W_IN +: W_IN], b_col[k*W_IN +: W_IN], signed_mode);
        end
    end

    for (genvar k = 0; k < NP2; k++) begin : g_leaf
        if (k < N) begin : g_used
            assign leaf[k] = SUM_W'(prod_p0[k]);
        end else begin : g_pad
            assign leaf[k] = '0;
        end
    end

    // adder tree stages: heap-ordered nodes, each node one register deep
    if (LVLS == 0) begin : g_single
        assign dot_sum = leaf[0];
    end else begin : g_tree
        logic signed [SUM_W-1:0] node [NP2-1];
        for (genvar n = 0; n < NP2 - 1; n++) begin : g_node
            logic signed [SUM_W-1:0] lhs;
            logic signed [SUM_W-1:0] rhs;
            if (2 * n + 1 >= NP2 - 1) begin : g_from_leaf
                assign lhs = leaf[2*n+1-(NP2-1)];
                assign rhs = leaf[2*n+2-(NP2-1)];
            end else begin : g_from_node
                assign lhs = node[2*n+1];
                assign rhs = node[2*n+2];
            end
            always_ff @(posedge clk) begin
                node[n] <= lhs + rhs;
            end
        end
        assign dot_sum = node[0];
    end

endmodule

// File: rtl/mat_mul_acc.sv
// N x N tile matrix multiply-accumulate over up to TILES K-tiles per job.
// Optional macro MAT_MUL_SAT_EN: saturate the accumulator instead of wrapping.
module mat_mul_acc
    import mat_mul_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int W_OUT = 32,
    parameter int N     = 8,
    parameter int TILES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic                   last_in,
    input  logic                   signed_mode,
    input  logic [N*N*W_IN-1:0]    matrix_1,
    input  logic [N*N*W_IN-1:0]    matrix_2,
    output logic                   valid_out,
    input  logic                   ready_out,
    output logic [N*N*W_OUT-1:0]   result,
    output logic                   tile_ovf
);
    localparam int LVLS  = pipe_depth(N) - 2;
    localparam int SUM_W = sum_width(W_IN, N);
    localparam int EXT_W = ((W_OUT > SUM_W) ? W_OUT : SUM_W) + 2;
    localparam int CNT_W = (TILES > 1) ? $clog2(TILES) : 1;

`ifdef MAT_MUL_SAT_EN
    localparam logic signed [EXT_W-1:0] S_MAX = {{(EXT_W-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] S_MIN = {{(EXT_W-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] U_MAX = {{(EXT_W-W_OUT){1'b0}}, {W_OUT{1'b1}}};

    function automatic logic [W_OUT-1:0] sat_acc(input logic signed [EXT_W-1:0] v,
                                                 input logic sgn);
        logic signed [EXT_W-1:0] hi;
        logic signed [EXT_W-1:0] lo;
        hi = sgn ? S_MAX : U_MAX;
        lo = sgn ? S_MIN : '0;
        if (v > hi) return hi[W_OUT-1:0];
        if (v < lo) return lo[W_OUT-1:0];
        return v[W_OUT-1:0];
    endfunction
`endif

    // The accumulator is reinterpreted per beat mode so the sum is exact before wrap/clamp.
    function automatic logic [W_OUT-1:0] acc_next(input logic [W_OUT-1:0] acc_q,
                                                  input logic signed [SUM_W-1:0] dot,
                                                  input logic sgn);
        logic signed [EXT_W-1:0] acc_x;
        acc_x = sgn ? EXT_W'($signed(acc_q)) : EXT_W'(acc_q);
`ifdef MAT_MUL_SAT_EN
        return sat_acc(acc_x + EXT_W'(dot), sgn);
`else
        return W_OUT'(acc_x + EXT_W'(dot));
`endif
    endfunction

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             job_ovf;
    logic             acc_last;
    logic             accept;
    logic             job_end;
    logic             job_done;
    logic             hold_enter;
    logic [LVLS:0]    vld_pipe;
    logic [LVLS:0]    last_pipe;
    logic [LVLS:0]    sgn_pipe;

    assign accept     = valid_in && ready_in;
    assign job_end    = last_in || (beat_cnt == CNT_W'(TILES - 1));
    assign job_done   = (state == HOLD) && ready_out;
    assign hold_enter = (state == DRAIN) && acc_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready_in  <= 1'b1;
            valid_out <= 1'b0;
            tile_ovf  <= 1'b0;
            job_ovf   <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (job_end) begin
                            state    <= DRAIN;
                            ready_in <= 1'b0;
                            job_ovf  <= ~last_in;
                            beat_cnt <= '0;
                        end else begin
                            state    <= ACCUM;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (acc_last) begin
                        state     <= HOLD;
                        valid_out <= 1'b1;
                        tile_ovf  <= job_ovf;
                    end
                end
                HOLD: begin
                    if (ready_out) begin
                        state     <= IDLE;
                        valid_out <= 1'b0;
                        tile_ovf  <= 1'b0;
                        ready_in  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // control pipeline, aligned with the dot-product data stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            sgn_pipe  <= '0;
            acc_last  <= 1'b0;
        end else begin
            vld_pipe[0]  <= accept;
            last_pipe[0] <= job_end;
            sgn_pipe[0]  <= signed_mode;
            for (int s = 1; s <= LVLS; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                last_pipe[s] <= last_pipe[s-1];
                sgn_pipe[s]  <= sgn_pipe[s-1];
            end
            acc_last <= vld_pipe[LVLS] && last_pipe[LVLS];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [N*W_IN-1:0]       a_row;
            logic [N*W_IN-1:0]       b_col;
            logic signed [SUM_W-1:0] dot_sum;
            logic [W_OUT-1:0]        acc;
            logic [W_OUT-1:0]        res_q;

            for (genvar k = 0; k < N; k++) begin : g_k
                assign a_row[k*W_IN +: W_IN] = matrix_1[elem_lsb(i, k, N, W_IN) +: W_IN];
                assign b_col[k*W_IN +: W_IN] = matrix_2[elem_lsb(k, j, N, W_IN) +: W_IN];
            end

            mat_mul_dot #(.W_IN(W_IN), .N(N)) u_dot (
                .clk         (clk),
                .signed_mode (signed_mode),
                .a_row       (a_row),
                .b_col       (b_col),
                .dot_sum     (dot_sum)
            );

            // accumulate stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc <= '0;
                end else if (job_done) begin
                    acc <= '0;
                end else if (vld_pipe[LVLS]) begin
                    acc <= acc_next(acc, dot_sum, sgn_pipe[LVLS]);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    res_q <= '0;
                end else if (hold_enter) begin
                    res_q <= acc;
                end
            end

            assign result[elem_lsb(i, j, N, W_OUT) +: W_OUT] = res_q;
        end
    end

endmodule
